// File: rtl/segment_pkg.sv
// rtl/segment_pkg.sv - shared FSM states, summary layout and counter widths for segment_checker
package segment_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_REPORT = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   localparam int CNT_W     = 32;
   localparam int ELAPSED_W = 64;

   localparam int SUM_PKTS_LSB    = 0;
   localparam int SUM_PKTS_W      = CNT_W;
   localparam int SUM_BEATS_LSB   = 32;
   localparam int SUM_BEATS_W     = CNT_W;
   localparam int SUM_BAD_LSB     = 64;
   localparam int SUM_BAD_W       = CNT_W;
   localparam int SUM_ELAPSED_LSB = 96;
   localparam int SUM_ELAPSED_W   = ELAPSED_W;
   localparam int SUMMARY_W       = 160;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/segment_checker_if.sv
// rtl/segment_checker_if.sv - received segment stream and summary stream bundle
interface segment_checker_if #(
   parameter int AXIS_TDATA_WIDTH      = 512,
   parameter int STREAMING_TDEST_WIDTH = 16,
   parameter int AXIS_SUMMARY_WIDTH    = 160
) ();

   logic [AXIS_TDATA_WIDTH-1:0]     S_AXIS_n2k_tdata;
   logic [AXIS_TDATA_WIDTH/8-1:0]   S_AXIS_n2k_tkeep;
   logic                            S_AXIS_n2k_tvalid;
   logic                            S_AXIS_n2k_tlast;
   logic [STREAMING_TDEST_WIDTH-1:0] S_AXIS_n2k_tdest;
   logic                            S_AXIS_n2k_tready;

   logic [AXIS_SUMMARY_WIDTH-1:0]   M_AXIS_summary_tdata;
   logic                            M_AXIS_summary_tvalid;
   logic                            M_AXIS_summary_tlast;
   logic                            M_AXIS_summary_tready;

   modport slave (
      input  S_AXIS_n2k_tdata, S_AXIS_n2k_tkeep, S_AXIS_n2k_tvalid,
      input  S_AXIS_n2k_tlast, S_AXIS_n2k_tdest,
      output S_AXIS_n2k_tready,
      output M_AXIS_summary_tdata, M_AXIS_summary_tvalid, M_AXIS_summary_tlast,
      input  M_AXIS_summary_tready
   );

   modport master (
      output S_AXIS_n2k_tdata, S_AXIS_n2k_tkeep, S_AXIS_n2k_tvalid,
      output S_AXIS_n2k_tlast, S_AXIS_n2k_tdest,
      input  S_AXIS_n2k_tready,
      input  M_AXIS_summary_tdata, M_AXIS_summary_tvalid, M_AXIS_summary_tlast,
      output M_AXIS_summary_tready
   );

endinterface

// File: rtl/segment_checker_stats.sv
// rtl/segment_checker_stats.sv - saturating packet, beat, bad-packet and elapsed counters
module segment_checker_stats
   import segment_pkg::*;
(
   input  logic                 ap_clk,
   input  logic                 ap_rst,
   input  logic                 clear,
   input  logic                 beat_en,
   input  logic                 pkt_en,
   input  logic                 pkt_bad,
   input  logic                 tick_en,
   output logic [CNT_W-1:0]     rx_packets,
   output logic [CNT_W-1:0]     rx_beats,
   output logic [CNT_W-1:0]     bad_packets,
   output logic [ELAPSED_W-1:0] elapsed
);

   always_ff @(posedge ap_clk) begin
      if (ap_rst || clear) begin
         rx_packets  <= '0;
         rx_beats    <= '0;
         bad_packets <= '0;
         elapsed     <= '0;
      end else begin
         if (beat_en)
            rx_beats <= sat_inc(rx_beats);
         if (pkt_en) begin
            rx_packets <= sat_inc(rx_packets);
            if (pkt_bad)
               bad_packets <= sat_inc(bad_packets);
         end
         if (tick_en && !(&elapsed))
            elapsed <= elapsed + 1'b1;
      end
   end

endmodule

// File: rtl/segment_checker.sv
// rtl/segment_checker.sv - checks a run of received segments and emits one summary word
// Optional payload index check: SEGMENT_CHECKER_PAYLOAD_CHECK_EN
module segment_checker
   import segment_pkg::*;
#(
   parameter int AXIS_TDATA_WIDTH      = 512,
   parameter int STREAMING_TDEST_WIDTH = 16,
   parameter int AXIS_SUMMARY_WIDTH    = 160
) (
   input  logic                             ap_clk,
   input  logic                             ap_rst,
   segment_checker_if.slave                 axis,
   input  logic [31:0]                      number_packets,
   input  logic [31:0]                      number_beats,
   input  logic [STREAMING_TDEST_WIDTH-1:0] expected_dest,
   input  logic                             ap_start,
   output logic                             ap_done,
   output logic                             ap_idle
);

   state_t state, state_next;

   logic [AXIS_TDATA_WIDTH-1:0]      rx_data;
   logic [AXIS_TDATA_WIDTH/8-1:0]    rx_keep;
   logic [STREAMING_TDEST_WIDTH-1:0] rx_dest;
   logic [STREAMING_TDEST_WIDTH-1:0] dest_q;
   logic [CNT_W-1:0]                 num_pkts_q, num_beats_q, pkt_beats, pkt_beats_inc;
   logic [CNT_W-1:0]                 rx_packets, rx_beats, bad_packets;
   logic [ELAPSED_W-1:0]             elapsed;
   logic [SUMMARY_W-1:0]             summary_word;
   logic pkt_err, started, clear, beat_acc, last_acc, beat_err, pkt_bad;
   logic final_beat, tick_en, payload_err, unused_payload;

   assign rx_data        = axis.S_AXIS_n2k_tdata;
   assign rx_keep        = axis.S_AXIS_n2k_tkeep;
   assign rx_dest        = axis.S_AXIS_n2k_tdest;
   assign unused_payload = ^rx_data;

   assign clear         = (state == ST_IDLE) && ap_start;
   assign beat_acc      = (state == ST_RUN) && axis.S_AXIS_n2k_tvalid;
   assign last_acc      = beat_acc && axis.S_AXIS_n2k_tlast;
   assign pkt_beats_inc = sat_inc(pkt_beats);

   // Partial tkeep is legal only on the closing beat of a packet.
   assign beat_err   = (rx_dest != dest_q) ||
                       (!axis.S_AXIS_n2k_tlast && !(&rx_keep)) || payload_err;
   assign pkt_bad    = pkt_err || beat_err || (pkt_beats_inc != num_beats_q);
   assign final_beat = last_acc && (sat_inc(rx_packets) == num_pkts_q);
   assign tick_en    = (state == ST_RUN) && (started || beat_acc);

`ifdef SEGMENT_CHECKER_PAYLOAD_CHECK_EN
   logic [CNT_W-1:0] beat_idx;

   always_ff @(posedge ap_clk) begin
      if (ap_rst || clear)
         beat_idx <= '0;
      else if (beat_acc)
         beat_idx <= beat_idx + 1'b1;
   end

   assign payload_err = (rx_data[CNT_W-1:0] != beat_idx);
`else
   assign payload_err = 1'b0;
`endif

   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         num_pkts_q  <= '0;
         num_beats_q <= '0;
         dest_q      <= '0;
         pkt_beats   <= '0;
         pkt_err     <= 1'b0;
         started     <= 1'b0;
      end else if (clear) begin
         num_pkts_q  <= number_packets;
         num_beats_q <= number_beats;
         dest_q      <= expected_dest;
         pkt_beats   <= '0;
         pkt_err     <= 1'b0;
         started     <= 1'b0;
      end else if (beat_acc) begin
         started <= 1'b1;
         if (axis.S_AXIS_n2k_tlast) begin
            pkt_beats <= '0;
            pkt_err   <= 1'b0;
         end else begin
            pkt_beats <= pkt_beats_inc;
            pkt_err   <= pkt_err || beat_err;
         end
      end
   end

   segment_checker_stats u_stats (
      .ap_clk      (ap_clk),
      .ap_rst      (ap_rst),
      .clear       (clear),
      .beat_en     (beat_acc),
      .pkt_en      (last_acc),
      .pkt_bad     (pkt_bad),
      .tick_en     (tick_en),
      .rx_packets  (rx_packets),
      .rx_beats    (rx_beats),
      .bad_packets (bad_packets),
      .elapsed     (elapsed)
   );

   always_comb begin
      summary_word = '0;
      summary_word[SUM_PKTS_LSB    +: SUM_PKTS_W]    = rx_packets;
      summary_word[SUM_BEATS_LSB   +: SUM_BEATS_W]   = rx_beats;
      summary_word[SUM_BAD_LSB     +: SUM_BAD_W]     = bad_packets;
      summary_word[SUM_ELAPSED_LSB +: SUM_ELAPSED_W] = elapsed;
   end

   always_ff @(posedge ap_clk) begin
      if (ap_rst)
         state <= ST_IDLE;
      else
         state <= state_next;
   end

   always_comb begin
      state_next                 = state;
      axis.S_AXIS_n2k_tready     = 1'b0;
      axis.M_AXIS_summary_tvalid = 1'b0;
      axis.M_AXIS_summary_tlast  = 1'b0;
      axis.M_AXIS_summary_tdata  = '0;
      ap_done                    = 1'b0;
      ap_idle                    = 1'b0;
      case (state)
         ST_IDLE: begin
            ap_idle = 1'b1;
            if (ap_start)
               state_next = (number_packets == '0) ? ST_REPORT : ST_RUN;
         end
         ST_RUN: begin
            axis.S_AXIS_n2k_tready = 1'b1;
            if (final_beat)
               state_next = ST_REPORT;
         end
         ST_REPORT: begin
            axis.M_AXIS_summary_tvalid = 1'b1;
            axis.M_AXIS_summary_tlast  = 1'b1;
            axis.M_AXIS_summary_tdata  = AXIS_SUMMARY_WIDTH'(summary_word);
            if (axis.M_AXIS_summary_tready)
               state_next = ST_DONE;
         end
         ST_DONE: begin
            ap_done    = 1'b1;
            state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

endmodule
